// File: rtl/vedio_src_ctrl.sv
// Frame scheduler and sync-geometry monitor for the simulation video source.
// Releases the source from reset per run, picks each frame's image file and flags malformed hsync/vsync timing.
module vedio_src_ctrl #(
  parameter int IW        = 640,
  parameter int IH        = 480,
  parameter int SRC_CHN   = 3,
  parameter int FRAME_NUM = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [1:0]       fix_sel,
  input  logic             src_hsync,
  input  logic             src_vsync,
  output logic             src_rst_n,
  output logic [1:0]       src_sel,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             err_line,
  output logic             err_frame,
  output logic             err_sync
);

  localparam logic [CNT_W-1:0] LINE_LEN    = CNT_W'(IW * SRC_CHN);
  localparam logic [CNT_W-1:0] FRAME_LINES = CNT_W'(IH);
  localparam logic [CNT_W-1:0] FRAME_LAST  = CNT_W'(FRAME_NUM);
  localparam bit               HAS_LIMIT   = (FRAME_NUM != 0);

  typedef enum logic [2:0] {IDLE, ARM, RUN, DRAIN, DONE} state_t;

  state_t           state_reg, state_next;
  logic             hs_reg, vs_reg;
  logic [1:0]       sel_reg, sel_next;
  logic             done_reg, done_next;
  logic             stop_pend_reg, stop_pend_next;
  logic [CNT_W-1:0] frame_cnt_reg, frame_cnt_next;
  logic [CNT_W-1:0] pix_cnt_reg, pix_cnt_next;
  logic [CNT_W-1:0] line_cnt_reg, line_cnt_next;
  logic             err_line_reg, err_line_next;
  logic             err_frame_reg, err_frame_next;
  logic             err_sync_reg, err_sync_next;

  logic             hs_rise, hs_fall, vs_rise, vs_fall;
  logic             active;
  logic [CNT_W-1:0] frame_inc;
  logic             last_frame;

  // Edges compare the raw input against last cycle's copy, so they fire in the cycle the input changes.
  assign hs_rise    = src_hsync & ~hs_reg;
  assign hs_fall    = ~src_hsync & hs_reg;
  assign vs_rise    = src_vsync & ~vs_reg;
  assign vs_fall    = ~src_vsync & vs_reg;
  assign active     = (state_reg == ARM) || (state_reg == RUN) || (state_reg == DRAIN);
  assign frame_inc  = frame_cnt_reg + CNT_W'(1);
  assign last_frame = HAS_LIMIT && (frame_inc == FRAME_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      hs_reg        <= 1'b0;
      vs_reg        <= 1'b0;
      sel_reg       <= 2'd0;
      done_reg      <= 1'b0;
      stop_pend_reg <= 1'b0;
      frame_cnt_reg <= '0;
      pix_cnt_reg   <= '0;
      line_cnt_reg  <= '0;
      err_line_reg  <= 1'b0;
      err_frame_reg <= 1'b0;
      err_sync_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      hs_reg        <= src_hsync;
      vs_reg        <= src_vsync;
      sel_reg       <= sel_next;
      done_reg      <= done_next;
      stop_pend_reg <= stop_pend_next;
      frame_cnt_reg <= frame_cnt_next;
      pix_cnt_reg   <= pix_cnt_next;
      line_cnt_reg  <= line_cnt_next;
      err_line_reg  <= err_line_next;
      err_frame_reg <= err_frame_next;
      err_sync_reg  <= err_sync_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    sel_next       = sel_reg;
    done_next      = 1'b0;
    stop_pend_next = stop_pend_reg;
    frame_cnt_next = frame_cnt_reg;
    pix_cnt_next   = pix_cnt_reg;
    line_cnt_next  = line_cnt_reg;
    err_line_next  = err_line_reg;
    err_frame_next = err_frame_reg;
    err_sync_next  = err_sync_reg;

    if (active && src_hsync && !src_vsync) err_sync_next = 1'b1;

    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next     = ARM;
          sel_next       = fix_sel;
          stop_pend_next = 1'b0;
          frame_cnt_next = '0;
          pix_cnt_next   = '0;
          line_cnt_next  = '0;
          err_line_next  = 1'b0;
          err_frame_next = 1'b0;
          err_sync_next  = 1'b0;
        end
      end
      ARM: begin
        if (stop) begin
          state_next = DONE;
          done_next  = 1'b1;
        end else if (vs_rise) begin
          state_next = RUN;
        end
      end
      RUN, DRAIN: begin
        if (src_hsync && (pix_cnt_reg != '1)) pix_cnt_next = pix_cnt_reg + CNT_W'(1);
        if (hs_fall) begin
          if (pix_cnt_reg != LINE_LEN) err_line_next = 1'b1;
          pix_cnt_next = '0;
        end
        if (hs_rise && (line_cnt_reg != '1)) line_cnt_next = line_cnt_reg + CNT_W'(1);
        if ((state_reg == RUN) && stop) begin
          stop_pend_next = 1'b1;
          state_next     = DRAIN;
        end
        // vsync fall closes a frame; a stop arriving in the same cycle still counts that frame.
        if (vs_fall) begin
          if (line_cnt_reg != FRAME_LINES) err_frame_next = 1'b1;
          line_cnt_next  = '0;
          frame_cnt_next = frame_inc;
          if (last_frame || stop_pend_next || (state_reg == DRAIN)) begin
            state_next = DONE;
            done_next  = 1'b1;
          end else begin
            case (mode)
              2'd1:    sel_next = sel_reg + 2'd1;
              2'd2:    sel_next = {1'b0, ~sel_reg[0]};
              default: sel_next = sel_reg;
            endcase
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign src_rst_n = active;
  assign busy      = active;
  assign src_sel   = sel_reg;
  assign done      = done_reg;
  assign frame_cnt = frame_cnt_reg;
  assign err_line  = err_line_reg;
  assign err_frame = err_frame_reg;
  assign err_sync  = err_sync_reg;

endmodule

// File: tb/tb_vedio_src_ctrl.sv
// Bench for vedio_src_ctrl: three instances (3, 4 and unlimited frames) share one bench-driven sync source.
// Expected file selects are queued at run start and popped at every vsync rise.
module tb_vedio_src_ctrl;

  localparam int IW       = 8;
  localparam int IH       = 4;
  localparam int SRC_CHN  = 3;
  localparam int LINE_LEN = IW * SRC_CHN;
  localparam int HB       = 4;
  localparam int VLOW     = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] start_v, stop_v;
  logic [1:0] mode, fix_sel;
  logic       src_hsync, src_vsync;

  logic [2:0]       src_rst_n_w, busy_w, done_w, err_line_w, err_frame_w, err_sync_w;
  logic [2:0][1:0]  src_sel_w;
  logic [2:0][15:0] fc_w;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_sel_q[$];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      vedio_src_ctrl #(
        .IW(IW), .IH(IH), .SRC_CHN(SRC_CHN),
        .FRAME_NUM(gi == 0 ? 3 : (gi == 1 ? 4 : 0)), .CNT_W(16)
      ) u_dut (
        .clk(clk), .rst(rst), .start(start_v[gi]), .stop(stop_v[gi]),
        .mode(mode), .fix_sel(fix_sel),
        .src_hsync(src_hsync), .src_vsync(src_vsync),
        .src_rst_n(src_rst_n_w[gi]), .src_sel(src_sel_w[gi]),
        .busy(busy_w[gi]), .done(done_w[gi]), .frame_cnt(fc_w[gi]),
        .err_line(err_line_w[gi]), .err_frame(err_frame_w[gi]), .err_sync(err_sync_w[gi])
      );
    end
  endgenerate

  // Packed {done, busy, src_rst_n, err_line, err_frame, err_sync} of one instance.
  function automatic logic [5:0] status(input int d);
    return {done_w[d], busy_w[d], src_rst_n_w[d], err_line_w[d], err_frame_w[d], err_sync_w[d]};
  endfunction

  task automatic set_sync(input logic h, input logic v);
    src_hsync = h;
    src_vsync = v;
    @(posedge clk);
    #1;
  endtask

  task automatic src_vlow(input int n);
    repeat (n) set_sync(1'b0, 1'b0);
  endtask

  task automatic pulse_start(input int d);
    start_v[d] = 1'b1;
    set_sync(1'b0, 1'b0);
    start_v = '0;
  endtask

  // Active part of a frame, ending with the vsync-fall cycle; optional short line and stop pulse.
  task automatic src_active(input int n_lines, input int bad_line, input int bad_len,
                            input int stop_dut, input int stop_line, input bit stop_at_fall);
    int len;
    set_sync(1'b0, 1'b1);
    set_sync(1'b0, 1'b1);
    for (int l = 0; l < n_lines; l++) begin
      len = (l == bad_line) ? bad_len : LINE_LEN;
      if (stop_dut >= 0 && l == stop_line) stop_v[stop_dut] = 1'b1;
      repeat (len) begin
        set_sync(1'b1, 1'b1);
        stop_v = '0;
      end
      repeat (HB) set_sync(1'b0, 1'b1);
    end
    set_sync(1'b0, 1'b1);
    if (stop_dut >= 0 && stop_at_fall) stop_v[stop_dut] = 1'b1;
    set_sync(1'b0, 1'b0);
    stop_v = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_v = '0; stop_v = '0; mode = 2'd0; fix_sel = 2'd0;
    set_sync(1'b0, 1'b0);
    set_sync(1'b0, 1'b0);
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (status(d) !== 6'b000000) begin
        n_fail++; $display("FAIL reset_status dut%0d: got %b expected 000000", d, status(d));
      end
      n_checks++;
      if (src_sel_w[d] !== 2'd0 || fc_w[d] !== 16'd0) begin
        n_fail++; $display("FAIL reset_sel_cnt dut%0d: got sel=%0d cnt=%0d expected 0/0", d, src_sel_w[d], fc_w[d]);
      end
    end
    $display("reset: all instances checked");
  endtask

  task automatic test_round_robin();
    int exp;
    mode = 2'd1; fix_sel = 2'd2;
    exp_sel_q.push_back(2); exp_sel_q.push_back(3); exp_sel_q.push_back(0);
    pulse_start(0);
    n_checks++;
    if (status(0) !== 6'b011000 || src_sel_w[0] !== 2'd2) begin
      n_fail++; $display("FAIL rr_start: got status=%b sel=%0d expected 011000 sel=2", status(0), src_sel_w[0]);
    end
    for (int f = 0; f < 3; f++) begin
      if (f == 1) begin
        // start while busy must be ignored
        src_vlow(3);
        start_v[0] = 1'b1;
        set_sync(1'b0, 1'b0);
        start_v = '0;
        src_vlow(2);
      end else begin
        src_vlow(VLOW);
      end
      exp = exp_sel_q.pop_front();
      n_checks++;
      if (src_sel_w[0] !== 2'(exp)) begin
        n_fail++; $display("FAIL rr_sel frame %0d: got %0d expected %0d", f, src_sel_w[0], exp);
      end
      src_active(IH, -1, 0, -1, -1, 1'b0);
      $display("rr frame %0d: sel=%0d frame_cnt=%0d status=%b", f, exp, fc_w[0], status(0));
      n_checks++;
      if (status(0) !== ((f < 2) ? 6'b011000 : 6'b100000) || fc_w[0] !== 16'(f + 1)) begin
        n_fail++; $display("FAIL rr_end frame %0d: got status=%b cnt=%0d expected cnt=%0d", f, status(0), fc_w[0], f + 1);
      end
    end
    set_sync(1'b0, 1'b0);
    n_checks++;
    if (status(0) !== 6'b000000 || fc_w[0] !== 16'd3) begin
      n_fail++; $display("FAIL rr_done_pulse: got status=%b cnt=%0d expected 000000 cnt=3", status(0), fc_w[0]);
    end
    n_checks++;
    if (exp_sel_q.size() != 0) begin
      n_fail++; $display("FAIL rr_queue: got %0d left expected 0", exp_sel_q.size());
    end
  endtask

  task automatic test_restart_fixed();
    int exp;
    mode = 2'd0; fix_sel = 2'd3;
    repeat (3) exp_sel_q.push_back(3);
    pulse_start(0);
    n_checks++;
    if (fc_w[0] !== 16'd0 || src_sel_w[0] !== 2'd3 || status(0) !== 6'b011000) begin
      n_fail++; $display("FAIL restart_clear: got cnt=%0d sel=%0d status=%b expected 0/3/011000", fc_w[0], src_sel_w[0], status(0));
    end
    for (int f = 0; f < 3; f++) begin
      src_vlow(VLOW);
      exp = exp_sel_q.pop_front();
      n_checks++;
      if (src_sel_w[0] !== 2'(exp)) begin
        n_fail++; $display("FAIL fixed_sel frame %0d: got %0d expected %0d", f, src_sel_w[0], exp);
      end
      src_active(IH, -1, 0, -1, -1, 1'b0);
      $display("fixed frame %0d: sel=%0d frame_cnt=%0d", f, exp, fc_w[0]);
    end
    n_checks++;
    if (status(0) !== 6'b100000 || fc_w[0] !== 16'd3) begin
      n_fail++; $display("FAIL fixed_end: got status=%b cnt=%0d expected 100000 cnt=3", status(0), fc_w[0]);
    end
  endtask

  task automatic test_ping_pong();
    int exp;
    mode = 2'd2; fix_sel = 2'd1;
    exp_sel_q.push_back(1); exp_sel_q.push_back(0); exp_sel_q.push_back(1); exp_sel_q.push_back(0);
    pulse_start(1);
    for (int f = 0; f < 4; f++) begin
      src_vlow(VLOW);
      exp = exp_sel_q.pop_front();
      n_checks++;
      if (src_sel_w[1] !== 2'(exp)) begin
        n_fail++; $display("FAIL pp_sel frame %0d: got %0d expected %0d", f, src_sel_w[1], exp);
      end
      src_active(IH, -1, 0, -1, -1, 1'b0);
      $display("pp frame %0d: sel=%0d frame_cnt=%0d status=%b", f, exp, fc_w[1], status(1));
      n_checks++;
      if (status(1) !== ((f < 3) ? 6'b011000 : 6'b100000) || fc_w[1] !== 16'(f + 1)) begin
        n_fail++; $display("FAIL pp_end frame %0d: got status=%b cnt=%0d expected cnt=%0d", f, status(1), fc_w[1], f + 1);
      end
    end
  endtask

  task automatic test_stop(input bit at_fall);
    int exp;
    mode = 2'd1; fix_sel = 2'd0;
    exp_sel_q.push_back(0); exp_sel_q.push_back(1);
    pulse_start(2);
    n_checks++;
    if (fc_w[2] !== 16'd0) begin
      n_fail++; $display("FAIL stop_start_cnt: got %0d expected 0", fc_w[2]);
    end
    for (int f = 0; f < 2; f++) begin
      src_vlow(VLOW);
      exp = exp_sel_q.pop_front();
      n_checks++;
      if (src_sel_w[2] !== 2'(exp)) begin
        n_fail++; $display("FAIL stop_sel frame %0d: got %0d expected %0d", f, src_sel_w[2], exp);
      end
      if (f == 1) src_active(IH, -1, 0, 2, at_fall ? -1 : 1, at_fall);
      else        src_active(IH, -1, 0, -1, -1, 1'b0);
      $display("stop(at_fall=%0b) frame %0d: frame_cnt=%0d status=%b", at_fall, f, fc_w[2], status(2));
      n_checks++;
      if (status(2) !== ((f == 0) ? 6'b011000 : 6'b100000) || fc_w[2] !== 16'(f + 1)) begin
        n_fail++; $display("FAIL stop_end frame %0d: got status=%b cnt=%0d expected cnt=%0d", f, status(2), fc_w[2], f + 1);
      end
    end
    src_vlow(VLOW);
    src_active(IH, -1, 0, -1, -1, 1'b0);
    n_checks++;
    if (status(2) !== 6'b000000 || fc_w[2] !== 16'd2 || src_sel_w[2] !== 2'd1) begin
      n_fail++; $display("FAIL stop_hold: got status=%b cnt=%0d sel=%0d expected 000000/2/1", status(2), fc_w[2], src_sel_w[2]);
    end
  endtask

  task automatic test_errors();
    mode = 2'd0; fix_sel = 2'd0;
    pulse_start(2);
    set_sync(1'b1, 1'b0);
    set_sync(1'b0, 1'b0);
    n_checks++;
    if (status(2) !== 6'b011001) begin
      n_fail++; $display("FAIL err_sync: got %b expected 011001", status(2));
    end
    src_vlow(VLOW);
    src_active(IH, 1, LINE_LEN - 1, -1, -1, 1'b0);
    $display("err frame short line: status=%b", status(2));
    n_checks++;
    if (status(2) !== 6'b011101) begin
      n_fail++; $display("FAIL err_line: got %b expected 011101", status(2));
    end
    src_vlow(VLOW);
    src_active(IH - 1, -1, 0, -1, -1, 1'b0);
    $display("err frame 3 lines: status=%b", status(2));
    n_checks++;
    if (status(2) !== 6'b011111) begin
      n_fail++; $display("FAIL err_frame: got %b expected 011111", status(2));
    end
    src_vlow(VLOW);
    src_active(IH, -1, 0, 2, 0, 1'b0);
    n_checks++;
    if (status(2) !== 6'b100111 || fc_w[2] !== 16'd3) begin
      n_fail++; $display("FAIL err_sticky: got status=%b cnt=%0d expected 100111 cnt=3", status(2), fc_w[2]);
    end
    pulse_start(2);
    n_checks++;
    if (status(2) !== 6'b011000 || fc_w[2] !== 16'd0) begin
      n_fail++; $display("FAIL err_clear: got status=%b cnt=%0d expected 011000 cnt=0", status(2), fc_w[2]);
    end
    stop_v[2] = 1'b1;
    set_sync(1'b0, 1'b0);
    stop_v = '0;
    n_checks++;
    if (status(2) !== 6'b100000) begin
      n_fail++; $display("FAIL stop_in_arm: got %b expected 100000", status(2));
    end
  endtask

  task automatic test_reset_mid_run();
    int exp;
    mode = 2'd1; fix_sel = 2'd2;
    pulse_start(0);
    src_vlow(VLOW);
    repeat (5) set_sync(1'b0, 1'b1);
    repeat (3) set_sync(1'b1, 1'b1);
    rst = 1'b1;
    set_sync(1'b1, 1'b1);
    rst = 1'b0;
    n_checks++;
    if (status(0) !== 6'b000000 || src_sel_w[0] !== 2'd0 || fc_w[0] !== 16'd0) begin
      n_fail++; $display("FAIL rst_mid_run: got status=%b sel=%0d cnt=%0d expected 000000/0/0", status(0), src_sel_w[0], fc_w[0]);
    end
    set_sync(1'b0, 1'b0);
    exp_sel_q.push_back(2); exp_sel_q.push_back(3); exp_sel_q.push_back(0);
    pulse_start(0);
    for (int f = 0; f < 3; f++) begin
      src_vlow(VLOW);
      exp = exp_sel_q.pop_front();
      n_checks++;
      if (src_sel_w[0] !== 2'(exp)) begin
        n_fail++; $display("FAIL rerun_sel frame %0d: got %0d expected %0d", f, src_sel_w[0], exp);
      end
      src_active(IH, -1, 0, -1, -1, 1'b0);
      $display("rerun frame %0d: sel=%0d frame_cnt=%0d", f, exp, fc_w[0]);
    end
    n_checks++;
    if (status(0) !== 6'b100000 || fc_w[0] !== 16'd3) begin
      n_fail++; $display("FAIL rerun_end: got status=%b cnt=%0d expected 100000 cnt=3", status(0), fc_w[0]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    src_hsync = 1'b0; src_vsync = 1'b0;
    rst = 1'b1; start_v = '0; stop_v = '0; mode = 2'd0; fix_sel = 2'd0;
    test_reset();
    test_round_robin();
    test_restart_fixed();
    test_ping_pong();
    test_stop(1'b0);
    test_stop(1'b1);
    test_errors();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vedio_src_ctrl.md
Name: vedio_src_ctrl

Overview:
- Frame scheduler and monitor for the simulation video source.
- Holds the source in reset until started, then runs a programmed number of frames.
- Before each frame's vsync rising edge (file-open point), selects which of the four source image files that frame uses.
- Checks every frame's hsync/vsync geometry against IW/IH/SRC_CHN and stops cleanly on frame boundaries; sits between the testbench control and the source.

Parameters:
- IW, 640: image width in pixels.
- IH, 480: image height in lines.
- SRC_CHN, 3: pixel clocks per pixel (channels).
- FRAME_NUM, 4: frames per run; 0 = run until stop.
- CNT_W, 16: width of internal counters and frame_cnt.

Ports:
- clk, in, 1: reference clock (same clock as the source pixel clock).
- rst, in, 1: synchronous active-high reset.
- start, in, 1: 1-cycle pulse; begins a run, accepted only in IDLE or DONE.
- stop, in, 1: 1-cycle pulse; ends the run at the next frame boundary.
- mode, in, 2: 0 fixed, 1 round-robin 0..3, 2 ping-pong 0/1, 3 treated as 0.
- fix_sel, in, 2: file index used in mode 0; also the first index in all modes.
- src_hsync, in, 1: hsync from the source.
- src_vsync, in, 1: vsync from the source.
- src_rst_n, out, 1: active-low reset driven to the source.
- src_sel, out, 2: file select driven to the source.
- busy, out, 1: high in ARM, RUN and DRAIN.
- done, out, 1: 1-cycle pulse on entry to DONE.
- frame_cnt, out, CNT_W: frames completed in the current run.
- err_line, out, 1: sticky; some line's hsync-high length ≠ IW*SRC_CHN.
- err_frame, out, 1: sticky; some frame's hsync-rise count ≠ IH.
- err_sync, out, 1: sticky; hsync seen high while vsync low.

Behaviour:
- Reset values: state=IDLE, src_rst_n=0, src_sel=0, busy=0, done=0, frame_cnt=0, all err=0, all internal counters=0.
- Reset mid-run returns to these values on the next edge.
- Input registers: src_hsync and src_vsync are registered once (hs_r, vs_r).
  - vs_rise = vs & ~vs_r; vs_fall = ~vs & vs_r; same for hsync.
  - Edges are detected the same cycle the raw input changes, against the registered copy.
- IDLE:
  - src_rst_n=0.
  - On start: src_sel<=fix_sel, frame_cnt<=0, errs<=0, counters<=0, go to ARM.
- ARM:
  - src_rst_n=1, busy=1. The source begins with vsync low.
  - On vs_rise go to RUN; no count or check is applied to this edge itself.
  - stop in ARM: go to DONE.
- RUN, per-line checks:
  - While hsync=1, pix_cnt increments.
  - On hs_fall: if pix_cnt ≠ IW*SRC_CHN, set err_line; then pix_cnt<=0.
  - On hs_rise: line_cnt increments.
  - If hsync=1 and vsync=0 in any cycle of ARM/RUN/DRAIN, set err_sync.
- RUN, frame boundary on vs_fall:
  - If line_cnt ≠ IH, set err_frame.
  - line_cnt<=0; frame_cnt<=frame_cnt+1.
  - If (FRAME_NUM≠0 and frame_cnt+1==FRAME_NUM) or a stop is pending: go to DONE.
  - Otherwise advance src_sel per mode: mode1 (sel+1) mod 4; mode2 sel^1 within {0,1} (ping-pong starts from fix_sel[0]); mode0/3 unchanged.
  - src_sel therefore changes during the vsync-low period and is stable ≥ V_SYNC lines before the next vs_rise.
- stop in RUN:
  - Latched into stop_pend and moves the state to DRAIN.
  - DRAIN behaves exactly like RUN, including checks, but always exits to DONE at the next vs_fall, counting that frame.
  - stop and vs_fall in the same cycle: that vs_fall completes the run (DONE), frame counted.
  - stop in DRAIN/DONE/IDLE: ignored.
- DONE:
  - done=1 for the entry cycle only; src_rst_n=0; busy=0.
  - frame_cnt and errs hold.
  - start restarts exactly as from IDLE. start and stop asserted together in IDLE/DONE: start wins, stop ignored.
- frame_cnt: wraps modulo 2^CNT_W. Internal pix_cnt and line_cnt saturate at all-ones instead of wrapping.
- Latency: src_rst_n rises 1 cycle after the start sample. done and src_rst_n falling occur 1 cycle after the vs_fall cycle.

Test Plan:
- IW=8, IH=4, SRC_CHN=3, FRAME_NUM=3, mode=1, fix_sel=2, source attached; pulse start → src_sel sequence 2,3,0 at the three vs_rises; done after the 3rd vs_fall; frame_cnt=3; all err=0; src_rst_n=0 afterwards.
- mode=2, fix_sel=1, FRAME_NUM=4 → src_sel 1,0,1,0; mode=0, fix_sel=3 → constant 3.
- FRAME_NUM=0, stop pulsed mid-frame 2 → DRAIN; done exactly at the end of frame 2; frame_cnt=2; stop coincident with vs_fall gives the same result.
- Bench-driven syncs: one line hsync high 23 cycles → err_line=1; frame with 3 hsync rises → err_frame=1; hsync pulse during vsync low → err_sync=1; all sticky until the next start.
- rst asserted during RUN → all outputs at reset values on the next edge; a subsequent start runs a clean full sequence with errs=0.
- start pulsed while busy → ignored (src_sel sequence and frame_cnt unaffected); start in DONE → new run with frame_cnt cleared.
